da2_dac_serializer: RTL and testbench



---
 rtl/da2_dac_serializer.sv | 214 +++++++++++++++++++++
 tb/tb_da2_dac_serializer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/da2_dac_serializer.sv
// -----------------------------------------------------------------------------
// da2_dac_serializer
//
// Serial transmitter for a Pmod DA2 (DAC121S101-class) converter. Accepts one
// 12-bit sample per valid/ready handshake and shifts it out MSB first as a
// 16-bit frame {2'b00, pd_mode, sample}, framed by sync_n, clocked by sclk.
// The DAC samples data on falling sclk edges; data changes on rising edges,
// giving half an SCLK period of setup and hold around each falling edge.
//
// Parameters:
//   CLK_DIV     clk cycles per SCLK half-period (>= 2)
//   GAP_CYCLES  clk cycles sync_n stays high between frames (>= 2)
//
// Ports:
//   clk           system clock
//   rst_n         synchronous active-low reset
//   sample_in     channel-A sample (unsigned, MSB first on the wire)
//   pd_mode       DAC power-down bits, captured with the sample
//   sample_valid  sample_in/pd_mode valid
//   sample_ready  block can accept a sample this cycle
//   busy          frame or inter-frame gap in progress
//   frame_done    one-cycle pulse when a frame completes
//   sync_n        DAC frame sync, active low
//   sclk          serial clock, idles high
//   sdata_a       serial data, channel A
//
// Build option DA2_DUAL_CHANNEL_EN adds sample_b_in / sdata_b: a second
// channel captured on the same handshake and shifted bit-synchronously with
// channel A, sharing pd bits, sync_n and sclk. Timing is identical.
// -----------------------------------------------------------------------------
module da2_dac_serializer #(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] sample_in,
  input  logic [1:0]  pd_mode,
  input  logic        sample_valid,
`ifdef DA2_DUAL_CHANNEL_EN
  input  logic [11:0] sample_b_in,
`endif
  output logic        sample_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        sync_n,
  output logic        sclk,
  output logic        sdata_a
`ifdef DA2_DUAL_CHANNEL_EN
  ,
  output logic        sdata_b
`endif
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state_reg,   state_next;
  logic [DIV_W-1:0]   div_reg,     div_next;
  logic [3:0]         bit_cnt_reg, bit_cnt_next;
  logic [GAP_W-1:0]   gap_reg,     gap_next;
  logic [15:0]        shift_a_reg, shift_a_next;
  logic               sclk_reg,    sclk_next;
  logic               sync_n_reg,  sync_n_next;
  logic               sdata_a_reg, sdata_a_next;
  logic               ready_reg,   ready_next;
  logic               busy_reg,    busy_next;
  logic               done_reg,    done_next;
`ifdef DA2_DUAL_CHANNEL_EN
  logic [15:0]        shift_b_reg, shift_b_next;
  logic               sdata_b_reg, sdata_b_next;
`endif

  logic tick;
  logic accept;

  assign tick   = (div_reg == DIV_W'(CLK_DIV - 1));
  assign accept = sample_valid && ready_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      div_reg     <= '0;
      bit_cnt_reg <= '0;
      gap_reg     <= '0;
      shift_a_reg <= '0;
      sclk_reg    <= 1'b1;
      sync_n_reg  <= 1'b1;
      sdata_a_reg <= 1'b0;
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
`ifdef DA2_DUAL_CHANNEL_EN
      shift_b_reg <= '0;
      sdata_b_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      div_reg     <= div_next;
      bit_cnt_reg <= bit_cnt_next;
      gap_reg     <= gap_next;
      shift_a_reg <= shift_a_next;
      sclk_reg    <= sclk_next;
      sync_n_reg  <= sync_n_next;
      sdata_a_reg <= sdata_a_next;
      ready_reg   <= ready_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
`ifdef DA2_DUAL_CHANNEL_EN
      shift_b_reg <= shift_b_next;
      sdata_b_reg <= sdata_b_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    div_next     = div_reg;
    bit_cnt_next = bit_cnt_reg;
    gap_next     = gap_reg;
    shift_a_next = shift_a_reg;
    sclk_next    = sclk_reg;
    sync_n_next  = sync_n_reg;
    done_next    = 1'b0;
`ifdef DA2_DUAL_CHANNEL_EN
    shift_b_next = shift_b_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        sclk_next   = 1'b1;
        sync_n_next = 1'b1;
        if (accept) begin
          shift_a_next = {2'b00, pd_mode, sample_in};
`ifdef DA2_DUAL_CHANNEL_EN
          shift_b_next = {2'b00, pd_mode, sample_b_in};
`endif
          div_next     = '0;
          bit_cnt_next = '0;
          sync_n_next  = 1'b0;
          state_next   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (!tick) begin
          div_next = div_reg + 1'b1;
        end else begin
          div_next = '0;
          if (sclk_reg) begin
            // Falling edge: the DAC samples, nothing moves here.
            sclk_next = 1'b0;
          end else if (bit_cnt_reg == 4'd15) begin
            // Rising edge after the 16th falling edge closes the frame.
            sclk_next   = 1'b1;
            sync_n_next = 1'b1;
            done_next   = 1'b1;
            gap_next    = '0;
            state_next  = ST_GAP;
          end else begin
            sclk_next    = 1'b1;
            shift_a_next = {shift_a_reg[14:0], 1'b0};
`ifdef DA2_DUAL_CHANNEL_EN
            shift_b_next = {shift_b_reg[14:0], 1'b0};
`endif
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end

      ST_GAP: begin
        sclk_next   = 1'b1;
        sync_n_next = 1'b1;
        if (gap_reg == GAP_W'(GAP_CYCLES - 1)) begin
          state_next = ST_IDLE;
        end else begin
          gap_next = gap_reg + 1'b1;
        end
      end

      default: begin
        state_next  = ST_IDLE;
        sclk_next   = 1'b1;
        sync_n_next = 1'b1;
      end
    endcase

    // Status and data pins are registered copies of the next-state view so
    // that they line up with sync_n/sclk on the same clock edge.
    ready_next   = (state_next == ST_IDLE);
    busy_next    = (state_next != ST_IDLE);
    sdata_a_next = (state_next == ST_SHIFT) ? shift_a_next[15] : 1'b0;
`ifdef DA2_DUAL_CHANNEL_EN
    sdata_b_next = (state_next == ST_SHIFT) ? shift_b_next[15] : 1'b0;
`endif
  end

  assign sample_ready = ready_reg;
  assign busy         = busy_reg;
  assign frame_done   = done_reg;
  assign sync_n       = sync_n_reg;
  assign sclk         = sclk_reg;
  assign sdata_a      = sdata_a_reg;
`ifdef DA2_DUAL_CHANNEL_EN
  assign sdata_b      = sdata_b_reg;
`endif

endmodule

// File: tb/tb_da2_dac_serializer.sv
// -----------------------------------------------------------------------------
// tb_da2_dac_serializer
//
// Two serializer instances: u0 with defaults (CLK_DIV=2, GAP_CYCLES=4) and
// u1 with CLK_DIV=5, GAP_CYCLES=3. Expected frames are pushed to a
// scoreboard on each observed handshake and popped on frame_done, where the
// word captured on falling sclk edges is compared. Frame timing is checked
// against the cycle numbers counted from the accept edge.
// -----------------------------------------------------------------------------
module tb_da2_dac_serializer;

  typedef struct packed {
    logic        inst;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [11:0] s0, s1, sb0, sb1;
  logic [1:0]  pd0, pd1;
  logic        v0, v1;

  logic d0_ready, d0_busy, d0_fd, d0_sync, d0_sclk, d0_sda, d0_sdb;
  logic d1_ready, d1_busy, d1_fd, d1_sync, d1_sclk, d1_sda, d1_sdb;

  da2_dac_serializer #(.CLK_DIV(2), .GAP_CYCLES(4)) u0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (s0),
    .pd_mode      (pd0),
    .sample_valid (v0),
`ifdef DA2_DUAL_CHANNEL_EN
    .sample_b_in  (sb0),
`endif
    .sample_ready (d0_ready),
    .busy         (d0_busy),
    .frame_done   (d0_fd),
    .sync_n       (d0_sync),
    .sclk         (d0_sclk),
    .sdata_a      (d0_sda)
`ifdef DA2_DUAL_CHANNEL_EN
    ,
    .sdata_b      (d0_sdb)
`endif
  );

  da2_dac_serializer #(.CLK_DIV(5), .GAP_CYCLES(3)) u1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (s1),
    .pd_mode      (pd1),
    .sample_valid (v1),
`ifdef DA2_DUAL_CHANNEL_EN
    .sample_b_in  (sb1),
`endif
    .sample_ready (d1_ready),
    .busy         (d1_busy),
    .frame_done   (d1_fd),
    .sync_n       (d1_sync),
    .sclk         (d1_sclk),
    .sdata_a      (d1_sda)
`ifdef DA2_DUAL_CHANNEL_EN
    ,
    .sdata_b      (d1_sdb)
`endif
  );

`ifndef DA2_DUAL_CHANNEL_EN
  assign d0_sdb = 1'b0;
  assign d1_sdb = 1'b0;
`endif

  logic [1:0] m_ready, m_busy, m_fd, m_sync, m_sclk, m_sda, m_sdb, m_valid;
  assign m_ready = {d1_ready, d0_ready};
  assign m_busy  = {d1_busy,  d0_busy};
  assign m_fd    = {d1_fd,    d0_fd};
  assign m_sync  = {d1_sync,  d0_sync};
  assign m_sclk  = {d1_sclk,  d0_sclk};
  assign m_sda   = {d1_sda,   d0_sda};
  assign m_sdb   = {d1_sdb,   d0_sdb};
  assign m_valid = {v1, v0};

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : 5;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int          acc_cyc [2];
  int          nfall   [2];
  int          low_cnt [2];
  logic        active  [2];
  logic [15:0] cap_a   [2];
  logic [15:0] cap_b   [2];
  logic [1:0]  p_sclk, p_ready, p_fd, p_sda, p_sdb;

  initial begin
    for (int i = 0; i < 2; i++) begin
      acc_cyc[i] = 0; nfall[i] = 0; low_cnt[i] = 0;
      active[i] = 1'b0; cap_a[i] = '0; cap_b[i] = '0;
    end
    p_sclk = 2'b11; p_ready = 2'b11; p_fd = 2'b00; p_sda = 2'b00; p_sdb = 2'b00;
  end

  always @(negedge clk) begin
    int   rel, d, g;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      rel = cyc - acc_cyc[i] + 1;
      d   = div_of(i);
      g   = gap_of(i);
      if (!rst_n) begin
        // Aborted frame never completes; drop its expectation.
        if (active[i] && exp_q.size() > 0) e = exp_q.pop_back();
        active[i]  = 1'b0;
        nfall[i]   = 0;
        low_cnt[i] = 0;
      end else begin
        if (active[i] && !p_ready[i] && m_ready[i]) begin
          chk($sformatf("ready_rise_u%0d", i), rel, 1 + 32 * d + g);
          active[i] = 1'b0;
        end
        if (active[i] && !m_sync[i]) low_cnt[i]++;
        if (active[i] && p_sclk[i] && !m_sclk[i] && !m_sync[i]) begin
          nfall[i]++;
          cap_a[i] = {cap_a[i][14:0], m_sda[i]};
          cap_b[i] = {cap_b[i][14:0], m_sdb[i]};
          chk($sformatf("fall_time_u%0d_k%0d", i, nfall[i]), rel, 1 + (2 * nfall[i] - 1) * d);
        end
        if (active[i] && !m_sync[i] && rel > 1 && (m_sda[i] != p_sda[i] || m_sdb[i] != p_sdb[i]))
          chk($sformatf("data_phase_u%0d", i), (rel - 1) % (2 * d), 0);
        if (p_fd[i]) chk($sformatf("done_width_u%0d", i), m_fd[i], 1'b0);
        if (m_fd[i]) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("sb_underflow_u%0d", i), 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("sb_inst_u%0d", i), e.inst, (i == 1));
            chk($sformatf("word_a_u%0d", i), cap_a[i], e.a);
`ifdef DA2_DUAL_CHANNEL_EN
            chk($sformatf("word_b_u%0d", i), cap_b[i], e.b);
`endif
          end
          chk($sformatf("done_time_u%0d", i), rel, 1 + 32 * d);
          chk($sformatf("sync_low_u%0d", i), low_cnt[i], 32 * d);
          chk($sformatf("nfall_u%0d", i), nfall[i], 16);
          chk($sformatf("done_pins_u%0d", i), {m_sync[i], m_sclk[i], m_sda[i]}, 3'b110);
        end
        if (m_valid[i] && m_ready[i]) begin
          e.inst = (i == 1);
          e.a    = (i == 0) ? {2'b00, pd0, s0}  : {2'b00, pd1, s1};
          e.b    = (i == 0) ? {2'b00, pd0, sb0} : {2'b00, pd1, sb1};
          exp_q.push_back(e);
          acc_cyc[i] = cyc + 1;
          active[i]  = 1'b1;
          nfall[i]   = 0;
          low_cnt[i] = 0;
        end
      end
    end
    p_sclk  = m_sclk;
    p_ready = m_ready;
    p_fd    = m_fd;
    p_sda   = m_sda;
    p_sdb   = m_sdb;
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int i, input logic [11:0] a, input logic [11:0] b, input logic [1:0] pd);
    if (i == 0) begin s0 = a; sb0 = b; pd0 = pd; v0 = 1'b1; end
    else        begin s1 = a; sb1 = b; pd1 = pd; v1 = 1'b1; end
  endtask

  // Returns the index of the accepting edge; leaves time at a negedge.
  task automatic wait_hs(input int i, output int t);
    logic ok = 1'b0;
    t = 0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (m_valid[i] && m_ready[i] && rst_n) begin
        t  = cyc + 1;
        ok = 1'b1;
      end
    end
    if (!ok) chk($sformatf("hs_timeout_u%0d", i), 1'b0, 1'b1);
  endtask

  task automatic send(input int i, input logic [11:0] a, input logic [11:0] b, input logic [1:0] pd);
    int t;
    drive(i, a, b, pd);
    wait_hs(i, t);
    @(posedge clk); #1;
    if (i == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    logic ok = 1'b0;
    for (int n = 0; n < 600 && !ok; n++) begin
      @(negedge clk);
      if (m_ready[i] && !m_busy[i]) ok = 1'b1;
    end
    if (!ok) chk($sformatf("idle_timeout_u%0d", i), 1'b0, 1'b1);
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t_acc [4];
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    s0 = '0; s1 = '0; sb0 = '0; sb1 = '0; pd0 = '0; pd1 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset: {sync_n, sclk, sdata, ready, busy, frame_done}.
    for (int n = 0; n < 10; n++) begin
      chk("idle_u0", {d0_sync, d0_sclk, d0_sda, d0_ready, d0_busy, d0_fd}, 6'b110100);
      chk("idle_u1", {d1_sync, d1_sclk, d1_sda, d1_ready, d1_busy, d1_fd}, 6'b110100);
      @(posedge clk); #1;
    end

    // Single frame, defaults.
    send(0, 12'hA5C, 12'h5A3, 2'b00);
    wait_idle(0);

    // Continuous valid with incrementing data: accepts 69 cycles apart.
    drive(0, 12'h100, 12'h0F0, 2'b01);
    for (int n = 0; n < 4; n++) begin
      wait_hs(0, t_acc[n]);
      @(posedge clk); #1;
      s0  = s0 + 12'h001;
      sb0 = sb0 + 12'h001;
      if (n > 0) chk($sformatf("accept_period_%0d", n), t_acc[n] - t_acc[n-1], 69);
    end
    v0 = 1'b0;
    wait_idle(0);

    // CLK_DIV=5 instance, pd=11, full-scale sample.
    send(1, 12'hFFF, 12'h000, 2'b11);
    wait_idle(1);

    // Reset asserted at cycle 20 of a frame.
    send(0, 12'h3C3, 12'hC3C, 2'b10);
    repeat (19) @(posedge clk);
    #1;
    chk("abort_partial", (nfall[0] > 0 && nfall[0] < 16), 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_pins", {d0_sync, d0_sclk, d0_sda, d0_ready, d0_busy}, 5'b11010);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 12'h7E1, 12'h18E, 2'b01);
    wait_idle(0);

`ifdef DA2_DUAL_CHANNEL_EN
    send(0, 12'h123, 12'hEDC, 2'b00);
    wait_idle(0);
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
